// File: rtl/ecrc_checker.sv
// ECRC checker: accumulates CRC-32 (poly 04C11DB7, MSB-first) over a framed TLP and
// compares the inverted result with the trailing digest DW, counting failing verdicts.
module ecrc_checker #(
  parameter int DATA_WIDTH   = 256,
  parameter int LENGTH_WIDTH = 4,
  parameter int POLY_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   ECRC_i_Data,
  input  logic [LENGTH_WIDTH-1:0] ECRC_i_Length,
  input  logic                    ECRC_i_Valid,
  input  logic                    ECRC_i_SOP,
  input  logic                    ECRC_i_EOP,
  output logic                    ECRC_o_Ready,
  output logic                    ECRC_o_Result_Valid,
  input  logic                    ECRC_i_Result_Ready,
  output logic                    ECRC_o_Pass,
  output logic                    ECRC_o_Framing_Err,
  output logic [15:0]             ECRC_o_Err_Count
);

  localparam int DW_W   = 32;
  localparam int NUM_DW = DATA_WIDTH / DW_W;
  localparam int CNT_W  = 3;
  localparam int SUM_W  = ((LENGTH_WIDTH > CNT_W) ? LENGTH_WIDTH : CNT_W) + 1;
  localparam logic [POLY_WIDTH-1:0] POLY   = POLY_WIDTH'(32'h04C1_1DB7);
  localparam logic [CNT_W-1:0]      MIN_DW = CNT_W'(4);
  localparam logic [DATA_WIDTH-1:0] VARIANT_MASK =
    (DATA_WIDTH'(1) << (DATA_WIDTH - 8)) | (DATA_WIDTH'(1) << (DATA_WIDTH - 18));

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_RESULT
  } state_e;

  function automatic logic [POLY_WIDTH-1:0] crc_dw(input logic [POLY_WIDTH-1:0] crc_in,
                                                   input logic [DW_W-1:0]       dw_in);
    logic [POLY_WIDTH-1:0] c;
    logic [DW_W-1:0]       d;
    logic                  fb;
    c = crc_in;
    d = dw_in;
    for (int unsigned b = 0; b < DW_W; b++) begin
      fb = c[POLY_WIDTH-1] ^ d[DW_W-1];
      c  = {c[POLY_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
      d  = {d[DW_W-2:0], 1'b0};
    end
    return c;
  endfunction

  state_e                  state_q, state_d;
  logic [POLY_WIDTH-1:0]   crc_q, crc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    len_err_q, len_err_d;
  logic                    pass_q, pass_d;
  logic                    frm_q, frm_d;
  logic [15:0]             err_cnt_q, err_cnt_d;
  logic                    live_q;

  logic                    accept, start, cont, abort, consume, len_bad;
  logic [LENGTH_WIDTH-1:0] n_crc;
  logic [DATA_WIDTH-1:0]   beat_sh, raw_sh;
  logic [POLY_WIDTH-1:0]   crc_beat;
  logic [DW_W-1:0]         digest;
  logic [CNT_W-1:0]        cnt_base, cnt_new;
  logic [SUM_W-1:0]        cnt_sum;
  logic                    len_err_new, frm_eop;

  always_comb begin
    accept  = ECRC_i_Valid && ECRC_o_Ready;
    start   = accept && ECRC_i_SOP && (state_q == S_IDLE);
    abort   = accept && ECRC_i_SOP && (state_q == S_ACCUM);
    cont    = accept && !ECRC_i_SOP && (state_q == S_ACCUM);
    consume = ECRC_o_Result_Valid && ECRC_i_Result_Ready;
    len_bad = (ECRC_i_Length == '0) || (ECRC_i_Length > LENGTH_WIDTH'(NUM_DW));
  end

  // Per-beat CRC: first n_crc DWs in order; the digest is the last valid DW of the beat
  always_comb begin
    beat_sh  = ECRC_i_Data | (start ? VARIANT_MASK : '0);
    raw_sh   = ECRC_i_Data;
    n_crc    = len_bad ? '0 : (ECRC_i_Length - LENGTH_WIDTH'(ECRC_i_EOP));
    crc_beat = start ? '1 : crc_q;
    digest   = '0;
    for (int unsigned i = 0; i < NUM_DW; i++) begin
      if (LENGTH_WIDTH'(i) < n_crc) begin
        crc_beat = crc_dw(crc_beat, beat_sh[DATA_WIDTH-1 -: DW_W]);
      end
      if (LENGTH_WIDTH'(i + 1) == ECRC_i_Length) begin
        digest = raw_sh[DATA_WIDTH-1 -: DW_W];
      end
      beat_sh = beat_sh << DW_W;
      raw_sh  = raw_sh << DW_W;
    end
  end

  // TLP length only matters up to the 4-DW minimum, so the count saturates there
  always_comb begin
    cnt_base    = start ? '0 : cnt_q;
    cnt_sum     = SUM_W'(cnt_base) + SUM_W'(ECRC_i_Length);
    cnt_new     = (cnt_sum >= SUM_W'(MIN_DW)) ? MIN_DW : CNT_W'(cnt_sum);
    len_err_new = (start ? 1'b0 : len_err_q) | len_bad;
    frm_eop     = len_err_new || (cnt_new < MIN_DW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = ECRC_i_EOP ? S_RESULT : S_ACCUM;
      end
      S_ACCUM: begin
        if (abort || (cont && ECRC_i_EOP)) state_d = S_RESULT;
      end
      S_RESULT: begin
        if (consume) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ECRC_o_Ready        = live_q && (state_q != S_RESULT);
    ECRC_o_Result_Valid = (state_q == S_RESULT);
    ECRC_o_Pass         = pass_q;
    ECRC_o_Framing_Err  = frm_q;
    ECRC_o_Err_Count    = err_cnt_q;
  end

  // An SOP arriving in ACCUM closes the open TLP as a framing error; its payload is discarded
  always_comb begin
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    len_err_d = len_err_q;
    pass_d    = pass_q;
    frm_d     = frm_q;
    err_cnt_d = err_cnt_q;
    if (start || cont) begin
      crc_d     = crc_beat;
      cnt_d     = cnt_new;
      len_err_d = len_err_new;
      if (ECRC_i_EOP) begin
        frm_d  = frm_eop;
        pass_d = !frm_eop && (DW_W'(~crc_beat) == digest);
      end
    end
    if (abort) begin
      frm_d  = 1'b1;
      pass_d = 1'b0;
    end
    if (consume) begin
      crc_d  = '1;
      pass_d = 1'b0;
      frm_d  = 1'b0;
      if (!pass_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q     <= '1;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
      pass_q    <= 1'b0;
      frm_q     <= 1'b0;
      err_cnt_q <= '0;
      live_q    <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
      pass_q    <= pass_d;
      frm_q     <= frm_d;
      err_cnt_q <= err_cnt_d;
      live_q    <= 1'b1;
    end
  end

endmodule

// File: doc/ecrc_checker.md
ECRC_CHECKER -- requirements
Module: ecrc_checker

Interface
REQ-001 Parameter: DATA_WIDTH, 256, beat width in bits (8 DW per beat).
REQ-002 Parameter: LENGTH_WIDTH, 4, width of per-beat DW count.
REQ-003 Parameter: POLY_WIDTH, 32, CRC width; polynomial fixed at 32'h04C11DB7.
REQ-004 Port: clk  in  1  single clock; all state on its rising edge.
REQ-005 Port: rst_n  in  1  reset; asynchronous, active-low.
REQ-006 Port: ECRC_i_Data  in  DATA_WIDTH  TLP beat; DW0 in bits 255:224, valid DWs MSB-aligned.
REQ-007 Port: ECRC_i_Length  in  LENGTH_WIDTH  valid DWs in beat (1..8).
REQ-008 Port: ECRC_i_Valid  in  1  beat present.
REQ-009 Port: ECRC_i_SOP / ECRC_i_EOP  in  1 each  first / last beat of TLP.
REQ-010 Port: ECRC_o_Ready  out  1  beat accepted when Valid && Ready.
REQ-011 Port: ECRC_o_Result_Valid  out  1  verdict available.
REQ-012 Port: ECRC_i_Result_Ready  in  1  verdict consumed when Result_Valid && Result_Ready.
REQ-013 Port: ECRC_o_Pass  out  1  1 = digest matches; 0 = mismatch.
REQ-014 Port: ECRC_o_Framing_Err  out  1  verdict is a framing error (Pass = 0).
REQ-015 Port: ECRC_o_Err_Count  out  16  saturating count of mismatches plus framing errors.

Function
REQ-016 States: IDLE, ACCUM, RESULT; rst_n low forces IDLE.
REQ-017 IDLE: Ready=1; accepted SOP beat seeds CRC with 32'hFFFF_FFFF; goes to ACCUM, or RESULT if EOP is also set.
REQ-018 ACCUM: Ready=1; each accepted beat updates CRC; accepted EOP beat -> RESULT.
REQ-019 RESULT: Ready=0; Result_Valid=1; Pass and Framing_Err held stable until consumed, then -> IDLE.
REQ-020 Latency: Result_Valid rises on the clock edge after the EOP beat is accepted.
REQ-021 Order: CRC processes DWs MSB-first, DW0 first; only the first ECRC_i_Length DWs of a beat are used.
REQ-022 EOP beat: the last valid DW is the received digest and is excluded from the CRC.
REQ-023 Variant bits: on the SOP beat, bit 248 (Type[0]) and bit 238 (EP) enter the CRC as 1 regardless of value.
REQ-024 Compare: Pass = (~CRC == digest DW), bitwise, no byte swap.
REQ-025 Framing error: total TLP length < 4 DW, Length of 0 or > 8, or SOP seen while in ACCUM.
REQ-026 Framing error verdict: Pass=0, Framing_Err=1, counted once; SOP in ACCUM aborts the open TLP without accepting that SOP beat.
REQ-027 Non-SOP beat in IDLE: dropped silently; no verdict, no count.
REQ-028 Valid low: no state or CRC change.
REQ-029 Err_Count: increments by 1 when a failing verdict is consumed; holds at 16'hFFFF.
REQ-030 Accept and consume in the same cycle is impossible, since Ready=0 in RESULT.
REQ-031 Back-to-back TLPs: a new SOP is accepted on the cycle after consume, giving a one-cycle bubble.

Reset
REQ-032 On rst_n low, immediately and independent of clk: state=IDLE, CRC=32'hFFFF_FFFF, Ready=0, Result_Valid=0, Pass=0, Framing_Err=0, Err_Count=0.
REQ-033 Ready rises on the first clk edge after rst_n deasserts.
REQ-034 Reset asserted mid-TLP or in RESULT discards the partial CRC and any pending verdict, with no count.

Verification
REQ-035 Single-beat TLP: 4 DW (3 DW header + correct digest from the bench model), SOP=EOP=1, Length=4 -> next cycle Result_Valid=1, Pass=1, Err_Count=0.
REQ-036 Same TLP with one payload bit flipped -> Pass=0, Framing_Err=0; Err_Count=1 after consume.
REQ-037 Same TLP with Type[0] and EP toggled -> Pass=1 (variant bits masked).
REQ-038 3-beat TLP (Length 8, 8, 3) with Result_Ready held low 5 cycles -> Ready=0 and verdict stable for 5 cycles; IDLE after consume.
REQ-039 SOP, then a second SOP before EOP -> Framing_Err=1, Pass=0, Err_Count=1; SOP+EOP with Length=2 -> another framing error, Err_Count=2.
REQ-040 rst_n pulsed low after beat 2 of a 3-beat TLP -> all outputs at reset values; next TLP checks Pass=1.
